// File: rtl/lsu_pkg.sv
// Shared constants, FSM encoding and decode helpers for the load/store memory controller.
package lsu_pkg;

  localparam int unsigned DEFAULT_TIMEOUT = 255;

  localparam logic [3:0] CODE_SB0 = 4'b0001;
  localparam logic [3:0] CODE_SB1 = 4'b0010;
  localparam logic [3:0] CODE_SB2 = 4'b0011;
  localparam logic [3:0] CODE_SB3 = 4'b0100;
  localparam logic [3:0] CODE_SH0 = 4'b0101;
  localparam logic [3:0] CODE_SH1 = 4'b0110;
  localparam logic [3:0] CODE_SH2 = 4'b0111;
  localparam logic [3:0] CODE_SW  = 4'b1111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StDone = 2'd2
  } lsu_state_e;

  typedef struct packed {
    logic       legal;
    logic [3:0] be;
    logic [1:0] shift;
  } we_dec_t;

  function automatic we_dec_t decode_we_code(input logic [3:0] code);
    we_dec_t d;
    d = '{legal: 1'b1, be: 4'b0000, shift: 2'd0};
    case (code)
      CODE_SB0: begin d.be = 4'b0001; d.shift = 2'd0; end
      CODE_SB1: begin d.be = 4'b0010; d.shift = 2'd1; end
      CODE_SB2: begin d.be = 4'b0100; d.shift = 2'd2; end
      CODE_SB3: begin d.be = 4'b1000; d.shift = 2'd3; end
      CODE_SH0: begin d.be = 4'b0011; d.shift = 2'd0; end
      CODE_SH1: begin d.be = 4'b0110; d.shift = 2'd1; end
      CODE_SH2: begin d.be = 4'b1100; d.shift = 2'd2; end
      CODE_SW:  begin d.be = 4'b1111; d.shift = 2'd0; end
      default:  d.legal = 1'b0;
    endcase
    return d;
  endfunction

  function automatic logic load_legal(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_LB, F3_LBU: return 1'b1;
      F3_LH, F3_LHU: return off != 2'b11;
      F3_LW:         return off == 2'b00;
      default:       return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] load_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_LB, F3_LBU: return 4'b0001 << off;
      F3_LH, F3_LHU: return 4'b0011 << off;
      default:       return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it.
module load_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] word_i,
  output logic [31:0] data_o
);

  logic [31:0] w_sh;

  assign w_sh = word_i >> {offset_i, 3'b000};

  always_comb begin
    data_o = '0;
    case (funct3_i)
      F3_LB:   data_o = {{24{w_sh[7]}}, w_sh[7:0]};
      F3_LBU:  data_o = {24'd0, w_sh[7:0]};
      F3_LH:   data_o = {{16{w_sh[15]}}, w_sh[15:0]};
      F3_LHU:  data_o = {16'd0, w_sh[15:0]};
      default: data_o = w_sh;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Single-outstanding load/store controller: decodes the request, runs a req/ack memory
// transaction with timeout, and returns extended load data with a one-cycle response pulse.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [3:0]        we_code_i,
  input  logic              mem_read_i,
  input  logic [2:0]        funct3_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic              resp_valid_o,
  output logic [31:0]       rdata_o,
  output logic              err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [31:0]       mem_rdata_i
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e        r_state, w_state_d;
  logic              r_mem_req, w_mem_req_d;
  logic              r_mem_we, w_mem_we_d;
  logic [3:0]        r_mem_be, w_mem_be_d;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_d;
  logic [31:0]       r_mem_wdata, w_mem_wdata_d;
  logic [2:0]        r_funct3, w_funct3_d;
  logic [1:0]        r_off, w_off_d;
  logic              r_is_load, w_is_load_d;
  logic [CNT_W-1:0]  r_cnt, w_cnt_d;
  logic [31:0]       r_rdata, w_rdata_d;
  logic              r_err, w_err_d;

  we_dec_t           w_dec;
  logic [31:0]       w_aligned;

  assign w_dec = decode_we_code(we_code_i);

  load_align u_load_align (
    .funct3_i (r_funct3),
    .offset_i (r_off),
    .word_i   (mem_rdata_i),
    .data_o   (w_aligned)
  );

  always_comb begin
    w_state_d     = r_state;
    w_mem_req_d   = r_mem_req;
    w_mem_we_d    = r_mem_we;
    w_mem_be_d    = r_mem_be;
    w_mem_addr_d  = r_mem_addr;
    w_mem_wdata_d = r_mem_wdata;
    w_funct3_d    = r_funct3;
    w_off_d       = r_off;
    w_is_load_d   = r_is_load;
    w_cnt_d       = r_cnt;
    w_rdata_d     = r_rdata;
    w_err_d       = r_err;

    unique case (r_state)
      StIdle: begin
        if (req_valid_i) begin
          w_funct3_d = funct3_i;
          w_off_d    = addr_i[1:0];
          if (we_code_i != 4'b0000) begin
            w_is_load_d = 1'b0;
            if (w_dec.legal) begin
              w_state_d     = StWait;
              w_mem_req_d   = 1'b1;
              w_mem_we_d    = 1'b1;
              w_mem_be_d    = w_dec.be;
              w_mem_addr_d  = {addr_i[ADDR_W-1:2], 2'b00};
              w_mem_wdata_d = wdata_i << {w_dec.shift, 3'b000};
              w_cnt_d       = '0;
            end else begin
              w_state_d = StDone;
              w_rdata_d = '0;
              w_err_d   = 1'b1;
            end
          end else if (mem_read_i) begin
            w_is_load_d = 1'b1;
            if (load_legal(funct3_i, addr_i[1:0])) begin
              w_state_d     = StWait;
              w_mem_req_d   = 1'b1;
              w_mem_we_d    = 1'b0;
              w_mem_be_d    = load_be(funct3_i, addr_i[1:0]);
              w_mem_addr_d  = {addr_i[ADDR_W-1:2], 2'b00};
              w_mem_wdata_d = '0;
              w_cnt_d       = '0;
            end else begin
              w_state_d = StDone;
              w_rdata_d = '0;
              w_err_d   = 1'b1;
            end
          end else begin
            w_state_d = StDone;
            w_rdata_d = '0;
            w_err_d   = 1'b0;
          end
        end
      end
      StWait: begin
        // Ack takes priority over the timeout limit in the same cycle.
        if (mem_ack_i) begin
          w_state_d   = StDone;
          w_mem_req_d = 1'b0;
          w_rdata_d   = r_is_load ? w_aligned : 32'd0;
          w_err_d     = 1'b0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_d   = StDone;
          w_mem_req_d = 1'b0;
          w_rdata_d   = '0;
          w_err_d     = 1'b1;
        end else begin
          w_cnt_d = r_cnt + CNT_W'(1);
        end
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= StIdle;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_be    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_funct3    <= '0;
      r_off       <= '0;
      r_is_load   <= 1'b0;
      r_cnt       <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_mem_req   <= w_mem_req_d;
      r_mem_we    <= w_mem_we_d;
      r_mem_be    <= w_mem_be_d;
      r_mem_addr  <= w_mem_addr_d;
      r_mem_wdata <= w_mem_wdata_d;
      r_funct3    <= w_funct3_d;
      r_off       <= w_off_d;
      r_is_load   <= w_is_load_d;
      r_cnt       <= w_cnt_d;
      r_rdata     <= w_rdata_d;
      r_err       <= w_err_d;
    end
  end

  assign req_ready_o  = (r_state == StIdle);
  assign resp_valid_o = (r_state == StDone);
  assign rdata_o      = r_rdata;
  assign err_o        = r_err;
  assign mem_req_o    = r_mem_req;
  assign mem_we_o     = r_mem_we;
  assign mem_be_o     = r_mem_be;
  assign mem_addr_o   = r_mem_addr;
  assign mem_wdata_o  = r_mem_wdata;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a transaction-level reference model checked every cycle.
module tb_lsu_mem_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [3:0]  we_code_i = '0;
  logic        mem_read_i = 1'b0;
  logic [2:0]  funct3_i = '0;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic        resp_valid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.ADDR_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .we_code_i    (we_code_i),
    .mem_read_i   (mem_read_i),
    .funct3_i     (funct3_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .resp_valid_o (resp_valid_o),
    .rdata_o      (rdata_o),
    .err_o        (err_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_be_o     (mem_be_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_ack_i    (mem_ack_i),
    .mem_rdata_i  (mem_rdata_i)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: bounded wait expired at %0t", name, $time);
  endtask

  // ---------------- reference model (transaction level) ----------------
  function automatic void code_info(input logic [3:0] c, output bit ok, output logic [3:0] be,
                                    output int sh);
    ok = 1'b1;
    be = 4'h0;
    sh = 0;
    case (c)
      4'b0001: begin be = 4'b0001; sh = 0; end
      4'b0010: begin be = 4'b0010; sh = 1; end
      4'b0011: begin be = 4'b0100; sh = 2; end
      4'b0100: begin be = 4'b1000; sh = 3; end
      4'b0101: begin be = 4'b0011; sh = 0; end
      4'b0110: begin be = 4'b0110; sh = 1; end
      4'b0111: begin be = 4'b1100; sh = 2; end
      4'b1111: begin be = 4'b1111; sh = 0; end
      default: ok = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] load_val(input logic [2:0] f3, input int off,
                                            input logic [31:0] w);
    int unsigned b, h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (8 * off)) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 128) ? b - 256 : b;
      3'b100:  return b;
      3'b001:  return (h >= 32768) ? h - 65536 : h;
      3'b101:  return h;
      3'b010:  return w;
      default: return 32'd0;
    endcase
  endfunction

  bit          m_on = 0;
  bit          m_ready, m_req, m_resp, m_we, m_err, m_load;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [2:0]  m_f3;
  int          m_off, m_waited;

  always @(posedge clk) begin
    bit ok;
    logic [3:0] be;
    int sh, nbytes;
    if (rst_i) begin
      m_on = 1; m_ready = 1; m_req = 0; m_resp = 0; m_we = 0; m_err = 0;
      m_be = 0; m_addr = 0; m_wdata = 0; m_rdata = 0;
    end else if (m_on) begin
      if (m_resp) begin
        m_resp = 0;
        m_ready = 1;
      end else if (m_req) begin
        if (mem_ack_i) begin
          m_req = 0; m_resp = 1; m_err = 0;
          m_rdata = m_load ? load_val(m_f3, m_off, mem_rdata_i) : 32'd0;
        end else begin
          m_waited++;
          if (m_waited == TO) begin
            m_req = 0; m_resp = 1; m_err = 1; m_rdata = 0;
          end
        end
      end else if (m_ready && req_valid_i) begin
        m_ready = 0;
        m_off = int'(addr_i % 4);
        m_f3 = funct3_i;
        if (we_code_i != 0) begin
          m_load = 0;
          code_info(we_code_i, ok, be, sh);
          if (ok) begin
            m_req = 1; m_waited = 0; m_we = 1; m_be = be;
            m_addr = addr_i - (addr_i % 4);
            m_wdata = wdata_i << (8 * sh);
          end else begin
            m_resp = 1; m_err = 1; m_rdata = 0;
          end
        end else if (mem_read_i) begin
          m_load = 1;
          nbytes = (funct3_i == 3'b010) ? 4 : ((funct3_i == 3'b001 || funct3_i == 3'b101) ? 2 :
                   ((funct3_i == 3'b000 || funct3_i == 3'b100) ? 1 : 0));
          if (nbytes != 0 && m_off + nbytes <= 4 && (nbytes != 4 || m_off == 0)) begin
            m_req = 1; m_waited = 0; m_we = 0;
            m_be = 4'(((1 << nbytes) - 1) << m_off);
            m_addr = addr_i - (addr_i % 4);
          end else begin
            m_resp = 1; m_err = 1; m_rdata = 0;
          end
        end else begin
          m_resp = 1; m_err = 0; m_rdata = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      chk("req_ready", req_ready_o, m_ready);
      chk("resp_valid", resp_valid_o, m_resp);
      chk("mem_req", mem_req_o, m_req);
      if (m_req) begin
        chk("mem_we", mem_we_o, m_we);
        chk("mem_be", mem_be_o, m_be);
        chk("mem_addr", mem_addr_o, m_addr);
        if (m_we) chk("mem_wdata", mem_wdata_o, m_wdata);
      end
      if (m_resp) begin
        chk("rdata", rdata_o, m_rdata);
        chk("err", err_o, m_err);
      end
    end
  end

  // ---------------- memory responder ----------------
  int ack_lat = 1;  // ack in this (1-based) cycle of mem_req; 0 = never
  int req_cnt = 0;
  logic force_ack = 1'b0;

  always @(negedge clk) begin
    if (mem_req_o) req_cnt++;
    else req_cnt = 0;
    mem_ack_i = force_ack || (mem_req_o && ack_lat != 0 && req_cnt == ack_lat);
  end

  // ---------------- drivers ----------------
  task automatic send(input logic [3:0] code, input logic rd, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wd);
    int n = 0;
    @(negedge clk);
    while (!req_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) fail_now("ready_wait");
    we_code_i = code; mem_read_i = rd; funct3_i = f3; addr_i = addr; wdata_i = wd;
    req_valid_i = 1'b1;
    @(posedge clk);
    #1 req_valid_i = 1'b0;
  endtask

  task automatic wait_resp(input string name, output int cyc, output int req_hi);
    cyc = 0;
    req_hi = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (mem_req_o) req_hi++;
    end while (!resp_valid_o && cyc < 50);
    if (!resp_valid_o) fail_now(name);
  endtask

  task automatic run(input string name, input logic [3:0] code, input logic rd,
                     input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rword,
                     input logic [31:0] exp_rdata, input logic exp_err, input int exp_cyc);
    int cyc, hi;
    mem_rdata_i = rword;
    send(code, rd, f3, addr, 32'h0);
    wait_resp(name, cyc, hi);
    chk({name, "_rdata"}, rdata_o, exp_rdata);
    chk({name, "_err"}, err_o, exp_err);
    chk({name, "_lat"}, cyc, exp_cyc);
  endtask

  initial begin
    int cyc, hi, resp_seen, n;

    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    chk("rst_ready", req_ready_o, 1);
    chk("rst_resp", resp_valid_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_mem_we", mem_we_o, 0);
    chk("rst_mem_be", mem_be_o, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_wdata", mem_wdata_o, 0);

    // Store SB2 with literal bus expectations.
    ack_lat = 1;
    send(4'b0011, 1'b0, 3'b000, 32'h102, 32'h0000_00AB);
    chk("st_req", mem_req_o, 1);
    chk("st_be", mem_be_o, 4'b0100);
    chk("st_addr", mem_addr_o, 32'h100);
    chk("st_wdata", mem_wdata_o, 32'h00AB_0000);
    chk("st_we", mem_we_o, 1);
    wait_resp("st_resp", cyc, hi);
    chk("st_err", err_o, 0);
    chk("st_lat", cyc, 2);

    // Loads.
    send(4'b0000, 1'b1, 3'b000, 32'h203, 32'h0);
    chk("lb_be", mem_be_o, 4'b1000);
    mem_rdata_i = 32'h80FF_7F01;
    wait_resp("lb_resp", cyc, hi);
    chk("lb_rdata", rdata_o, 32'hFFFF_FF80);
    run("lbu", 4'b0000, 1'b1, 3'b100, 32'h203, 32'h80FF_7F01, 32'h0000_0080, 1'b0, 2);
    run("lh", 4'b0000, 1'b1, 3'b001, 32'h202, 32'h8001_1234, 32'hFFFF_8001, 1'b0, 2);
    run("lhu", 4'b0000, 1'b1, 3'b101, 32'h200, 32'h1234_F00D, 32'h0000_F00D, 1'b0, 2);
    run("lw", 4'b0000, 1'b1, 3'b010, 32'h204, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 2);
    run("sh1", 4'b0110, 1'b1, 3'b010, 32'h305, 32'h0, 32'h0, 1'b0, 2);

    // Errors and no-op: response the cycle after acceptance, no memory access.
    run("lw_mis", 4'b0000, 1'b1, 3'b010, 32'h201, 32'h0, 32'h0, 1'b1, 1);
    run("lh_off3", 4'b0000, 1'b1, 3'b001, 32'h203, 32'h0, 32'h0, 1'b1, 1);
    run("bad_code", 4'b1000, 1'b0, 3'b000, 32'h200, 32'h0, 32'h0, 1'b1, 1);
    run("bad_f3", 4'b0000, 1'b1, 3'b011, 32'h200, 32'h0, 32'h0, 1'b1, 1);
    run("noop", 4'b0000, 1'b0, 3'b000, 32'h200, 32'h0, 32'h0, 1'b0, 1);

    // Timeout, then stale acks in idle.
    ack_lat = 0;
    send(4'b0000, 1'b1, 3'b010, 32'h400, 32'h0);
    wait_resp("to_resp", cyc, hi);
    chk("to_req_cycles", hi, TO);
    chk("to_err", err_o, 1);
    chk("to_rdata", rdata_o, 0);
    force_ack = 1'b1;
    resp_seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid_o) resp_seen++;
    end
    force_ack = 1'b0;
    chk("stale_ack_resp", resp_seen, 0);

    // Ack in the same cycle the limit is reached.
    ack_lat = TO;
    run("ack_at_limit", 4'b0000, 1'b1, 3'b010, 32'h500, 32'h1357_9BDF, 32'h1357_9BDF, 1'b0,
        TO + 1);

    // Back-to-back with req_valid held high; fields change during WAIT.
    ack_lat = 2;
    mem_rdata_i = 32'h0000_00F0;
    @(negedge clk);
    we_code_i = 4'b1111; mem_read_i = 1'b0; addr_i = 32'h600; wdata_i = 32'hCAFE_F00D;
    req_valid_i = 1'b1;
    @(posedge clk);
    #1 we_code_i = 4'b0000; mem_read_i = 1'b1; funct3_i = 3'b000; addr_i = 32'h700;
    wait_resp("b2b_first", cyc, hi);
    chk("b2b_first_lat", cyc, 3);
    @(negedge clk);
    chk("b2b_ready", req_ready_o, 1);
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    wait_resp("b2b_second", cyc, hi);
    chk("b2b_second_rdata", rdata_o, 32'hFFFF_FFF0);

    // Reset while waiting.
    ack_lat = 0;
    send(4'b0000, 1'b1, 3'b010, 32'h800, 32'h0);
    @(negedge clk);
    rst_i = 1'b1;
    @(posedge clk);
    #1 rst_i = 1'b0;
    chk("rstw_req", mem_req_o, 0);
    chk("rstw_ready", req_ready_o, 1);
    chk("rstw_resp", resp_valid_o, 0);
    n = 0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid_o) n++;
    end
    chk("rstw_no_resp", n, 0);
    ack_lat = 1;
    run("after_rst", 4'b0000, 1'b1, 3'b100, 32'h901, 32'h0000_A500, 32'h0000_00A5, 1'b0, 2);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish at %0t", $time);
    $fatal(1);
  end

endmodule
